// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
// Shared definitions for the execute-stage iterative divider.
//   div_state_e   : sequencer states (idle, iterating, result presented)
//   DIV_ITER      : default operand width, which is also the iteration count
//   DIV_ZERO_QUO_BIT : bit replicated across the quotient on divide-by-zero
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // One restoring step per result bit, so the iteration count equals the width.
  localparam int DIV_ITER = 32;

  // Divide-by-zero yields an all-ones quotient; replicated to any width.
  localparam logic DIV_ZERO_QUO_BIT = 1'b1;

endpackage : div_ctrl_pkg

// File: rtl/div_step.sv
// div_step
// One combinational radix-2 restoring division step.
// Ports:
//   rem_i  : partial remainder entering the step (always < dvsr_i)
//   quo_i  : dividend bits still to be consumed (MSB first), with quotient
//            bits accumulating from the LSB end
//   dvsr_i : divisor magnitude
//   rem_o  : partial remainder after the step
//   quo_o  : shifted quotient register with the new quotient bit in the LSB
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic             carry;
  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // Shift {rem,quo} left by one. The bit shifted out of rem is an implicit
  // extra MSB of the shifted remainder; if it is set the divisor always fits.
  // When the divisor fits, the true difference is below the divisor, so the
  // modulo-2^WIDTH subtraction already gives the exact new remainder.
  always_comb begin
    carry  = rem_i[WIDTH-1];
    rem_sh = {rem_i[WIDTH-2:0], quo_i[WIDTH-1]};
    trial  = rem_sh - dvsr_i;
    fits   = carry | (rem_sh >= dvsr_i);
    rem_o  = fits ? trial : rem_sh;
    quo_o  = {quo_i[WIDTH-2:0], fits};
  end

endmodule : div_step

// File: rtl/div_ctrl.sv
// div_ctrl
// Sequencer for the iterative DIV/DIVU unit in the execute stage. Accepts the
// operands of a divide in E, runs WIDTH restoring steps on the magnitudes,
// applies sign correction and presents HI/LO for one cycle with doneE.
// Ports:
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   startE      : valid DIV/DIVU in E (held while E is stalled)
//   signedE     : 1 = DIV (two's complement), 0 = DIVU
//   aE, bE      : dividend / divisor after forwarding
//   annulE      : exception flush of E, aborts any divide in flight
//   stall_divE  : combinational stall request to the hazard unit
//   hiE, loE    : remainder / quotient, qualified by doneE
//   doneE       : result valid; the instruction leaves E at the next edge
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] aE,
  input  logic [WIDTH-1:0] bE,
  input  logic             annulE,
  output logic             stall_divE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE,
  output logic             doneE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Operand magnitudes. The most negative value maps onto itself, which read
  // as unsigned is exactly its magnitude, so the overflow case 0x80000000/-1
  // produces 0x80000000 without any special handling.
  always_comb begin
    a_neg = signedE & aE[WIDTH-1];
    b_neg = signedE & bE[WIDTH-1];
    a_mag = a_neg ? -aE : aE;
    b_mag = b_neg ? -bE : bE;
  end

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // The stall must be visible in the same cycle the divide arrives in E, and
  // must drop as soon as a flush is seen, so it is purely combinational.
  assign stall_divE = startE & ~annulE & (state_q != DIV_DONE);
  assign doneE      = (state_q == DIV_DONE);
  assign hiE        = hi_q;
  assign loE        = lo_q;

  // Next-state and datapath logic. Result registers are only written when a
  // divide completes, so an aborted operation leaves the previous result in
  // place and nothing but doneE marks the outputs as fresh.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (startE && !annulE) begin
          if (bE == '0) begin
            // Divide-by-zero skips the iteration entirely; the remainder is
            // the raw dividend, not its magnitude.
            hi_d    = aE;
            lo_d    = {WIDTH{DIV_ZERO_QUO_BIT}};
            state_d = DIV_DONE;
          end else begin
            quo_d   = a_mag;
            dvsr_d  = b_mag;
            rem_d   = '0;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            count_d = '0;
            state_d = DIV_BUSY;
          end
        end
      end

      DIV_BUSY: begin
        if (annulE || !startE) begin
          state_d = DIV_IDLE;
        end else begin
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            // Final step: the quotient takes the XOR of operand signs, the
            // remainder the sign of the dividend.
            lo_d    = q_neg_q ? -step_quo : step_quo;
            hi_d    = r_neg_q ? -step_rem : step_rem;
            count_d = '0;
            state_d = DIV_DONE;
          end
        end
      end

      DIV_DONE: begin
        state_d = DIV_IDLE;
      end

      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl
// Self-checking bench for div_ctrl at WIDTH = 32. Expected quotient and
// remainder come from plain 64-bit arithmetic on operand magnitudes; expected
// timing is WIDTH+1 stall cycles (one for divide-by-zero) then one doneE cycle.
module tb_div_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         startE;
  logic         signedE;
  logic [W-1:0] aE;
  logic [W-1:0] bE;
  logic         annulE;
  logic         stall_divE;
  logic [W-1:0] hiE;
  logic [W-1:0] loE;
  logic         doneE;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] last_hi;
  logic [W-1:0] last_lo;

  always #5 clk = ~clk;

  div_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .startE     (startE),
    .signedE    (signedE),
    .aE         (aE),
    .bE         (bE),
    .annulE     (annulE),
    .stall_divE (stall_divE),
    .hiE        (hiE),
    .loE        (loE),
    .doneE      (doneE)
  );

  // Reference: divide magnitudes with native arithmetic, then apply signs.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input bit s, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    longint unsigned ma, mb, q64, r64;
    bit na, nb;
    if (b == 0) begin
      q = '1;
      r = a;
      return;
    end
    na  = s && a[W-1];
    nb  = s && b[W-1];
    ma  = na ? (64'h1_0000_0000 - {32'b0, a}) : {32'b0, a};
    mb  = nb ? (64'h1_0000_0000 - {32'b0, b}) : {32'b0, b};
    q64 = ma / mb;
    r64 = ma % mb;
    q   = (na ^ nb) ? 32'(64'd0 - q64) : 32'(q64);
    r   = na ? 32'(64'd0 - r64) : 32'(r64);
  endfunction

  function automatic int exp_stalls(input logic [W-1:0] b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  // Drives one divide starting just after a rising edge and observes it until
  // doneE (bounded). Returns to the caller #1 after the edge ending DONE.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         output int stalls, output bit seen, output bit overlap,
                         output logic [W-1:0] hi, output logic [W-1:0] lo);
    startE  = 1'b1;
    signedE = s;
    aE      = a;
    bE      = b;
    stalls  = 0;
    seen    = 1'b0;
    overlap = 1'b0;
    hi      = '0;
    lo      = '0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (doneE) begin
        seen    = 1'b1;
        hi      = hiE;
        lo      = loE;
        overlap = stall_divE;
      end else if (stall_divE) begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    startE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; startE = 1'b0; signedE = 1'b0; annulE = 1'b0; aE = '0; bE = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({stall_divE, doneE, hiE, loE} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got stall=%b done=%b hi=%h lo=%h required all zero",
               stall_divE, doneE, hiE, loE);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall_divE, doneE} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got stall=%b done=%b required 0 0", stall_divE, doneE);
    end
    @(posedge clk); #1;
  endtask

  // Runs a table of divides, comparing timing and results against the model.
  task automatic test_table(input string name, input logic [W-1:0] av[],
                            input logic [W-1:0] bv[], input bit sv[]);
    int st; bit seen, ov; logic [W-1:0] h, l, eq, er;
    for (int i = 0; i < av.size(); i++) begin
      ref_div(av[i], bv[i], sv[i], eq, er);
      run_div(av[i], bv[i], sv[i], st, seen, ov, h, l);
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]_done: doneE never seen within 200 cycles", name, i);
        continue;
      end
      vectors++;
      if (st != exp_stalls(bv[i]) || ov) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]_stalls: got %0d (stall in done=%b) required %0d",
                 name, i, st, ov, exp_stalls(bv[i]));
      end
      vectors++;
      if (l !== eq) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]_lo: %h/%h s=%b got %h required %h", name, i, av[i], bv[i], sv[i], l, eq);
      end
      vectors++;
      if (h !== er) begin
        miscompares++;
        $display("[TB] FAIL %s[%0d]_hi: %h/%h s=%b got %h required %h", name, i, av[i], bv[i], sv[i], h, er);
      end
      last_hi = er;
      last_lo = eq;
    end
  endtask

  task automatic test_unsigned();
    test_table("divu", '{32'd100, 32'hFFFF_FFFF, 32'd5}, '{32'd7, 32'd1, 32'd9}, '{1'b0, 1'b0, 1'b0});
  endtask

  task automatic test_signed();
    test_table("div", '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FF9C},
               '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF9}, '{1'b1, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_div_by_zero();
    test_table("divzero", '{32'h1234, 32'hFFFF_FFF0}, '{32'h0, 32'h0}, '{1'b0, 1'b1});
  endtask

  task automatic test_back_to_back();
    test_table("b2b", '{32'd100, 32'd50}, '{32'd7, 32'd5}, '{1'b0, 1'b0});
  endtask

  task automatic test_abort();
    bit saw_done;
    logic [W-1:0] h0, l0;
    h0 = last_hi;
    l0 = last_lo;
    startE = 1'b1; signedE = 1'b0; aE = 32'd1000; bE = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    annulE = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall_divE !== 1'b0 || doneE !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_same_cycle: got stall=%b done=%b required 0 0", stall_divE, doneE);
    end
    @(posedge clk); #1;
    annulE = 1'b0;
    startE = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (doneE) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("[TB] FAIL abort_no_done: got doneE=1 after annul required none");
    end
    vectors++;
    if (hiE !== h0 || loE !== l0) begin
      miscompares++;
      $display("[TB] FAIL abort_hold: got hi=%h lo=%h required hi=%h lo=%h", hiE, loE, h0, l0);
    end
    test_table("after_abort", '{32'd9}, '{32'd3}, '{1'b0});
  endtask

  task automatic test_reset_mid_busy();
    bit saw_done;
    startE = 1'b1; signedE = 1'b0; aE = 32'd100; bE = 32'd7;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    startE = 1'b0;
    @(negedge clk);
    vectors++;
    if ({stall_divE, doneE, hiE, loE} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_busy: got stall=%b done=%b hi=%h lo=%h required all zero",
               stall_divE, doneE, hiE, loE);
    end
    @(posedge clk); #1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (doneE) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("[TB] FAIL reset_no_done: got doneE=1 after reset required none");
    end
    last_hi = '0;
    last_lo = '0;
  endtask

  task automatic test_random();
    logic [W-1:0] av[16];
    logic [W-1:0] bv[16];
    bit           sv[16];
    for (int i = 0; i < 16; i++) begin
      av[i] = $urandom;
      case ($urandom_range(0, 7))
        0:       bv[i] = '0;
        1, 2:    bv[i] = W'($urandom_range(1, 15));
        3:       bv[i] = -W'($urandom_range(1, 15));
        default: bv[i] = $urandom;
      endcase
      sv[i] = 1'($urandom_range(0, 1));
    end
    test_table("random", av, bv, sv);
  endtask

  initial begin
    last_hi = '0;
    last_lo = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_div_ctrl

// File: doc/div_ctrl.md
# div_ctrl

Sequencer for the iterative divider serving DIV/DIVU in the execute stage of the five-stage MIPS pipeline. It accepts the operands of a divide sitting in E and runs a radix-2 restoring divide over WIDTH cycles. While the result is pending it raises `stall_divE` to the hazard unit, and it presents HI/LO results for one cycle when the instruction may leave E. An exception flush or a vanished request aborts the operation cleanly.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `startE`  in  1: a valid DIV/DIVU is in E; held high while E is stalled.
- `signedE`  in  1: 1 = DIV (two's complement), 0 = DIVU.
- `aE`  in  WIDTH: dividend (rs value after forwarding).
- `bE`  in  WIDTH: divisor (rt value after forwarding).
- `annulE`  in  1: exception flush of E (driven from `except_logicM`).
- `stall_divE`  out  1: holds F/D/E and bubbles M while the divide is pending.
- `hiE`  out  WIDTH: remainder, valid when `doneE` is high.
- `loE`  out  WIDTH: quotient, valid when `doneE` is high.
- `doneE`  out  1: result valid this cycle; the instruction advances at the next edge.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - If `startE & ~annulE & bE != 0`: latch |aE| and |bE| (magnitudes only when `signedE`), latch the quotient sign (`aE[W-1]^bE[W-1]`) and remainder sign (`aE[W-1]`), clear the partial remainder, set count = 0, go to BUSY.
  - If `startE & ~annulE & bE == 0`: go straight to DONE with the results defined below.
- **BUSY**
  - Each cycle performs one shift-subtract step: shift {rem,quo} left 1, trial subtract, keep the result if non-negative, quotient bit = ~borrow.
  - count increments each step.
  - After step WIDTH-1, apply sign correction (negate quotient and/or remainder per the latched signs) into the result registers and go to DONE.
- **DONE**: `doneE` = 1 for exactly one cycle, then go to IDLE unconditionally.
- **Divide-by-zero result**: `loE` = all ones, `hiE` = aE as latched. Defined for determinism; the architecture leaves it undefined.
- **Signed overflow**: 0x80000000 / -1 gives lo = 0x80000000, hi = 0. This falls out of the magnitude path with no special case.
- **Abort**: `annulE` high, or `startE` low in BUSY, sends the FSM to IDLE at the next edge and discards the results. `annulE` takes priority over every transition except `rst`.
- `stall_divE` = `startE & ~annulE & (state != DONE)`. It is combinational so the hazard unit sees it in the same cycle the divide enters E.
- **Reset**: state = IDLE, count = 0, all datapath registers 0.
- **Reset outputs**: `stall_divE` = 0 (given `startE` = 0), `doneE` = 0, `hiE` = `loE` = 0.

## Timing
- **Normal divide entering E at cycle 0**:
  - `stall_divE` is high in cycles 0..WIDTH (33 cycles at WIDTH = 32).
  - Cycle WIDTH+1 is DONE: `stall_divE` low, `doneE` high, results valid.
  - The instruction leaves E at the end of cycle WIDTH+1.
- **Divide by zero**: stall in cycle 0 only; DONE in cycle 1.
- **Back-to-back divides**: the DONE cycle consumes the current request. The next divide in E at DONE+1 finds the FSM in IDLE and starts without a gap cycle.
- **`annulE` in any cycle**: `stall_divE` drops in that same cycle, and the FSM is in IDLE at the next edge. A divide in E that cycle is lost, as required by the flush.
- **`rst`** has priority over `annulE` and `startE`; the FSM is in IDLE on the cycle after `rst`.
- Results hold their value after DONE until the next operation completes. Only `doneE` qualifies them.

## Structure
- Shared package:
  - state encoding (`DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`);
  - `DIV_ITER` = WIDTH;
  - divide-by-zero quotient constant.
- Sub-module `div_step`: purely combinational restoring step taking {rem,quo,divisor} and returning {rem',quo'}. `div_ctrl` keeps the FSM, counter, sign handling and result registers.

## Test plan
- **Unsigned divide**: DIVU 100 / 7 → `stall_divE` high exactly 33 cycles; `doneE` in cycle 33 with lo = 14, hi = 2.
- **Signed divide**: DIV -7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. Also DIV 7 / -2 → lo = 0xFFFFFFFD, hi = 1.
- **Edge cases**:
  - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - DIVU 0xFFFFFFFF / 1 → lo = 0xFFFFFFFF, hi = 0.
- **Divide by zero**: DIVU 0x1234 / 0 → one stall cycle; `doneE` next cycle with lo = 0xFFFFFFFF, hi = 0x1234.
- **Abort**:
  - Assert `annulE` at cycle 10 of a divide → `stall_divE` low the same cycle, no `doneE`, FSM IDLE.
  - A following DIVU 9 / 3 returns lo = 3, hi = 0.
- **Back-to-back and reset**:
  - Two divides back to back (100/7, then 50/5) → second starts the cycle after the first DONE and yields lo = 10, hi = 0.
  - `rst` pulsed mid-BUSY → all outputs 0 next cycle.
